// File: rtl/diff_pkg.sv
// Shared definitions for the differencer / integrator pair: default widths,
// integrator state encoding and fixed-width saturation helpers.
package diff_pkg;

    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_AW = 24;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic signed [DEF_AW-1:0] DW_MAX = DEF_AW'(2**(DEF_DW-1) - 1);
    localparam logic signed [DEF_AW-1:0] DW_MIN = DEF_AW'(-(2**(DEF_DW-1)));

    function automatic logic signed [DEF_DW-1:0] clip_dw(input logic signed [DEF_AW-1:0] v);
        if (v > DW_MAX)
            clip_dw = DW_MAX[DEF_DW-1:0];
        else if (v < DW_MIN)
            clip_dw = DW_MIN[DEF_DW-1:0];
        else
            clip_dw = v[DEF_DW-1:0];
    endfunction

    // Two's complement overflow shows up as disagreement of the top two sum bits.
    function automatic logic signed [DEF_AW-1:0] sat_add_aw(input logic signed [DEF_AW-1:0] a,
                                                            input logic signed [DEF_DW-1:0] b);
        logic signed [DEF_AW:0] s;
        s = (DEF_AW+1)'(a) + (DEF_AW+1)'(b);
        if (s[DEF_AW] != s[DEF_AW-1])
            sat_add_aw = s[DEF_AW] ? {1'b1, {(DEF_AW-1){1'b0}}} : {1'b0, {(DEF_AW-1){1'b1}}};
        else
            sat_add_aw = s[DEF_AW-1:0];
    endfunction

endpackage

// File: rtl/diff_integrator_sat_clip.sv
// Signed saturating narrow from IW to OW bits with an overflow flag.
module sat_clip
    import diff_pkg::*;
#(
    parameter int unsigned IW = DEF_AW + 1,
    parameter int unsigned OW = DEF_AW
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);

    logic [IW-OW:0] top;

    // The value fits only if every bit from the output sign bit upward is equal.
    assign top = din[IW-1:OW-1];
    assign ovf = !((&top) || !(|top));

    always_comb begin
        if (!ovf)
            dout = din[OW-1:0];
        else if (din[IW-1])
            dout = {1'b1, {(OW-1){1'b0}}};
        else
            dout = {1'b0, {(OW-1){1'b1}}};
    end

endmodule

// File: rtl/diff_integrator.sv
// Saturating integrator restoring absolute samples from a first-difference stream.
// Optional leak toward zero is enabled by defining LEAK_EN.
module diff_integrator
    import diff_pkg::*;
#(
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned WARMUP     = 2,
    parameter int unsigned LEAK_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 in_en,
    input  logic                 clr,
    output logic signed [DW-1:0] dout,
    output logic                 out_en,
    output logic                 sat,
    output logic                 locked
);

    if (AW <= DW || WARMUP > 15 || LEAK_SHIFT >= AW) begin : g_bad_cfg
        $error("diff_integrator: invalid parameter set");
    end

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic acc_load;

    logic signed [DW-1:0] d1;
    logic                 v1;
    logic signed [AW-1:0] acc, acc_next;
    logic signed [AW:0]   sum;
    logic signed [DW-1:0] out_clip;
    logic                 acc_ovf, out_ovf;

`ifdef LEAK_EN
    assign sum = (AW+1)'(acc) + (AW+1)'(d1) - (AW+1)'(acc >>> LEAK_SHIFT);
`else
    assign sum = (AW+1)'(acc) + (AW+1)'(d1);
`endif

    sat_clip #(.IW(AW + 1), .OW(AW)) u_acc_clip (
        .din  (sum),
        .dout (acc_next),
        .ovf  (acc_ovf)
    );

    sat_clip #(.IW(AW), .OW(DW)) u_out_clip (
        .din  (acc_next),
        .dout (out_clip),
        .ovf  (out_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (WARMUP == 0) ? RUN : WARM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_load   = 1'b0;
        if (clr) begin
            state_next = (WARMUP == 0) ? RUN : WARM;
            cnt_next   = '0;
        end else if (v1) begin
            case (state)
                WARM: begin
                    cnt_next = cnt + 4'd1;
                    if (cnt_next == 4'(WARMUP))
                        state_next = RUN;
                end
                RUN:     acc_load = 1'b1;
                default: state_next = WARM;
            endcase
        end
    end

    assign locked = (state == RUN);

    // Accumulator saturation implies the narrower output clip, so either flag marks sat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1     <= '0;
            v1     <= 1'b0;
            acc    <= '0;
            dout   <= '0;
            sat    <= 1'b0;
            out_en <= 1'b0;
        end else begin
            d1     <= din;
            v1     <= in_en && !clr;
            out_en <= acc_load;
            if (clr) begin
                acc <= '0;
            end else if (acc_load) begin
                acc  <= acc_next;
                dout <= out_clip;
                sat  <= out_ovf || acc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_diff_integrator.sv
// Directed scoreboard bench for diff_integrator (WARMUP=2, LEAK_SHIFT=2).
module tb_diff_integrator;

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 24;
    localparam int unsigned WARMUP     = 2;
    localparam int unsigned LEAK_SHIFT = 2;

    localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));
    localparam longint OUT_MAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint OUT_MIN = -(64'sd1 <<< (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] din;
    logic                 in_en;
    logic                 clr;
    logic signed [DW-1:0] dout;
    logic                 out_en;
    logic                 sat;
    logic                 locked;

    diff_integrator #(
        .DW(DW), .AW(AW), .WARMUP(WARMUP), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .in_en(in_en), .clr(clr),
        .dout(dout), .out_en(out_en), .sat(sat), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dout;
        bit sat;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    longint m_acc;
    int     m_cnt;
    bit     m_run;
    bit     p_v;
    int     p_d;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_run = (WARMUP == 0);
        p_v   = 1'b0;
    endtask

    // Reference behaviour for one accepted sample leaving the input register.
    task automatic process(input int d);
        longint s;
        exp_t   e;
        if (!m_run) begin
            m_cnt++;
            if (m_cnt == WARMUP) m_run = 1'b1;
        end else begin
            s = m_acc + d;
`ifdef LEAK_EN
            s = s - (m_acc >>> LEAK_SHIFT);
`endif
            if (s > ACC_MAX) s = ACC_MAX;
            if (s < ACC_MIN) s = ACC_MIN;
            m_acc = s;
            if (s > OUT_MAX) begin
                e.dout = int'(OUT_MAX); e.sat = 1'b1;
            end else if (s < OUT_MIN) begin
                e.dout = int'(OUT_MIN); e.sat = 1'b1;
            end else begin
                e.dout = int'(s); e.sat = 1'b0;
            end
            q.push_back(e);
        end
    endtask

    task automatic step(input logic v, input int d, input logic c);
        in_en = v;
        din   = DW'(d);
        clr   = c;
        if (c) begin
            model_clear();
        end else begin
            if (p_v) process(p_d);
            p_v = v;
            p_d = d;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic resync();
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < int'(WARMUP); i++) step(1'b1, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_en) begin
            if (q.size() == 0) begin
                check("unexpected_out_en", 32'(out_en), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("dout", 32'(dout), 32'(e.dout));
                check("sat", 32'(sat), 32'(e.sat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; din = '0; in_en = 1'b0; clr = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_out_en", 32'(out_en), 32'(0));
        check("rst_sat", 32'(sat), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        rst = 1'b0;

        // Warm-up: 5 and 7 discarded, then 3 and 4.
        step(1'b1, 5, 1'b0);
        step(1'b1, 7, 1'b0);
        check("locked_warm", 32'(locked), 32'(0));
        step(1'b1, 3, 1'b0);
        check("locked_run", 32'(locked), 32'(1));
        check("lat_early", 32'(out_en), 32'(0));
        step(1'b1, 1, 1'b0);
        check("lat_out_en", 32'(out_en), 32'(1));
        check("lat_dout", 32'(dout), 32'(3));
        idle(3);
        check("drain_warm", q.size(), 0);
`ifndef LEAK_EN
        check("warm_final", 32'(dout), 32'(4));
`endif

        // Round trip through a first-difference of a 0 -> 1000 step.
        begin
            int prev;
            int x;
            resync();
            prev = 0;
            for (int i = 0; i < 10; i++) begin
                x = (i < 3) ? 0 : 1000;
                step(1'b1, x - prev, 1'b0);
                prev = x;
            end
            idle(3);
        end
        check("drain_roundtrip", q.size(), 0);
`ifndef LEAK_EN
        check("roundtrip_level", 32'(dout), 32'(1000));
        check("roundtrip_sat", 32'(sat), 32'(0));
`endif

        // Output clip while accumulator keeps the true value.
        resync();
        step(1'b1, 20000, 1'b0);
        step(1'b1, 20000, 1'b0);
        step(1'b1, -10000, 1'b0);
        idle(3);
        check("drain_clip", q.size(), 0);
`ifndef LEAK_EN
        check("clip_recover", 32'(dout), 32'(30000));
        check("clip_recover_sat", 32'(sat), 32'(0));
`endif

        // Accumulator saturation at both limits, then walk back in range.
        resync();
        for (int i = 0; i < 260; i++) step(1'b1, -32768, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b1, 32767, 1'b0);
        idle(3);
        check("drain_negsat", q.size(), 0);
`ifndef LEAK_EN
        check("negsat_walk", 32'(dout), 32'(-256));
`endif
        resync();
        for (int i = 0; i < 260; i++) step(1'b1, 32767, 1'b0);
        for (int i = 0; i < 255; i++) step(1'b1, -32768, 1'b0);
        idle(3);
        check("drain_possat", q.size(), 0);
`ifndef LEAK_EN
        check("possat_walk", 32'(dout), 32'(32767));
        check("possat_walk_sat", 32'(sat), 32'(0));
`endif

        // clr together with a valid sample: sample dropped, warm-up restarts.
        resync();
        step(1'b1, 500, 1'b0);
        idle(2);
        step(1'b1, 9, 1'b1);
        check("clr_locked", 32'(locked), 32'(0));
        check("clr_out_en", 32'(out_en), 32'(0));
        step(1'b1, 11, 1'b0);
        step(1'b1, 12, 1'b0);
        step(1'b1, 13, 1'b0);
        idle(3);
        check("drain_clr", q.size(), 0);
        check("clr_restart", 32'(dout), 32'(13));

        // Asynchronous reset in the middle of a burst.
        step(1'b1, 100, 1'b0);
        step(1'b1, 200, 1'b0);
        in_en = 1'b1; din = DW'(300); clr = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'(0));
        check("arst_out_en", 32'(out_en), 32'(0));
        check("arst_sat", 32'(sat), 32'(0));
        check("arst_locked", 32'(locked), 32'(0));
        model_clear();
        q.delete();
        @(negedge clk);
        in_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        check("arst_rewarm", 32'(locked), 32'(0));
        step(1'b1, 3, 1'b0);
        step(1'b1, 4, 1'b0);
        idle(3);
        check("drain_arst", q.size(), 0);
        check("arst_restart", 32'(dout), 32'(7));

        // Leak decay (or hold without leak) from 1024 with zero input.
        resync();
        step(1'b1, 1024, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b0);
        idle(3);
        check("drain_leak", q.size(), 0);
`ifdef LEAK_EN
        check("leak_final", 32'(dout), 32'(183));
`else
        check("noleak_hold", 32'(dout), 32'(1024));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
